// File: rtl/r4booth_iter_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit of the multiplier and one
// partial product are folded into the accumulator per clock, with valid/ready on both sides.
module r4booth_iter_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    input  logic                 multiplicand_signed_i,
    input  logic                 multiplier_signed_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);
    // state  | meaning
    // S_IDLE | waiting for operands, in_ready_o high
    // S_BUSY | one Booth digit accumulated per cycle
    // S_DONE | product_o valid, waiting for out_ready_i

    localparam int NDIG = (WIDTH + 2) / 2;
    localparam int EXTW = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CNTW = $clog2(NDIG);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNTW-1:0]     r_cnt;
    logic [ACCW-1:0]     r_acc;
    logic [ACCW-1:0]     r_a;
    logic [EXTW:0]       r_b;
    logic [2*WIDTH-1:0]  r_product;

    logic                w_accept;
    logic [EXTW-1:0]     w_a_ext;
    logic [EXTW-1:0]     w_b_ext;
    logic [2:0]          w_win;
    logic                w_mul1x;
    logic                w_mul2x;
    logic                w_neg;
    logic [ACCW-1:0]     w_pp;
    logic [ACCW-1:0]     w_pp_sel;
    logic [ACCW-1:0]     w_acc_nxt;

    assign w_accept = (r_state == S_IDLE) && in_valid_i && !flush_i;

    assign w_a_ext = {{2{multiplicand_signed_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
    assign w_b_ext = {{2{multiplier_signed_i & multiplier_i[WIDTH-1]}}, multiplier_i};

    // Window sits in the low three bits of r_b; r_b carries the implicit zero below B's LSB.
    assign w_win   = r_b[2:0];
    assign w_mul1x = w_win[1] ^ w_win[0];
    assign w_mul2x = (w_win == 3'b011) || (w_win == 3'b100);
    // Zero digits (000/111) never negate, so they contribute a clean 0.
    assign w_neg   = w_win[2] & (w_mul1x | w_mul2x);

    assign w_pp      = w_mul2x ? (r_a << 1) : (w_mul1x ? r_a : '0);
    assign w_pp_sel  = w_neg ? ~w_pp : w_pp;
    assign w_acc_nxt = r_acc + w_pp_sel + {{(ACCW-1){1'b0}}, w_neg};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid_i)       w_state_nxt = S_BUSY;
                S_BUSY: if (r_cnt == '0)      w_state_nxt = S_DONE;
                S_DONE: if (out_ready_i)      w_state_nxt = S_IDLE;
                default:                      w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_cnt <= CNTW'(NDIG - 1);
            r_acc <= '0;
            r_a   <= {{(ACCW-EXTW){w_a_ext[EXTW-1]}}, w_a_ext};
            r_b   <= {w_b_ext, 1'b0};
        end else if (r_state == S_BUSY && !flush_i) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 2;
            r_b   <= r_b >> 2;
            if (r_cnt == '0) begin
                r_product <= w_acc_nxt[2*WIDTH-1:0];
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state == S_BUSY);
    assign product_o   = r_product;

endmodule
